uop_sequencer: RTL and testbench

Microcode sequencer for the curve point-arithmetic engine. It walks a synchronous microprogram ROM such as the point-addition or doubling program, decodes each 20-bit micro-operation and issues it to the operand-bank/modular-arithmetic datapath over a valid/ready handshake. It tracks the zero/non-zero flags produced by `CMP` micro-ops and evaluates each micro-op's execution condition. It stops at the first `RDY` opcode and reports completion to the curve-level controller.

---
 rtl/uop_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_uop_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uop_sequencer
// Description : Microcode sequencer for the curve point-arithmetic engine.
//               Walks a registered microprogram ROM, evaluates each micro-op's
//               execution condition against the CMP-derived flags, and issues
//               enabled micro-ops to the datapath over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uop_sequencer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic              rdy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [19:0]       rom_data,
    output logic              op_ena,
    output logic [3:0]        op_code,
    output logic [4:0]        op_src1,
    output logic [4:0]        op_src2,
    output logic [3:0]        op_dst,
    input  logic              op_rdy,
    input  logic              cmp_eq
);

    // Encodings shared with the microcode header
    localparam logic [3:0] C_OP_RDY         = 4'h0;
    localparam logic [3:0] C_OP_CMP         = 4'h5;
    localparam logic [4:0] C_SRC_PZ         = 5'd8;
    localparam logic [4:0] C_SRC_T1         = 5'd11;
    localparam logic [4:0] C_SRC_T2         = 5'd12;
    localparam logic [1:0] C_COND_ALWAYS    = 2'd0;
    localparam logic [1:0] C_COND_PZT1T2_0XX = 2'd1;
    localparam logic [1:0] C_COND_PZT1T2_100 = 2'd2;
    localparam logic [1:0] C_COND_PZT1T2_101 = 2'd3;

    localparam logic [ADDR_W-1:0] C_PC_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ena_dly;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pz_nz;
    logic              r_t1_nz;
    logic              r_t2_nz;
    logic [3:0]        r_op_code;
    logic [4:0]        r_op_src1;
    logic [4:0]        r_op_src2;
    logic [3:0]        r_op_dst;

    logic              w_start;
    logic              w_pc_last;
    logic              w_cond_ok;
    logic              w_dec_rdy;
    logic              w_dec_issue;
    logic              w_dec_skip;
    logic              w_wait_done;
    logic [3:0]        w_dec_code;
    logic [1:0]        w_dec_cond;

    assign w_start     = ena & ~r_ena_dly;
    assign w_pc_last   = (r_pc == C_PC_LAST);
    assign w_dec_code  = rom_data[19:16];
    assign w_dec_cond  = rom_data[1:0];
    assign w_dec_rdy   = (r_state == S_DECODE) && (w_dec_code == C_OP_RDY);
    assign w_dec_issue = (r_state == S_DECODE) && (w_dec_code != C_OP_RDY) && w_cond_ok;
    assign w_dec_skip  = (r_state == S_DECODE) && (w_dec_code != C_OP_RDY) && !w_cond_ok;
    assign w_wait_done = (r_state == S_WAIT) && op_rdy;

    // Execution condition of the micro-op currently on the ROM output
    always_comb begin
        w_cond_ok = 1'b0;
        case (w_dec_cond)
            C_COND_ALWAYS:     w_cond_ok = 1'b1;
            C_COND_PZT1T2_0XX: w_cond_ok = !r_pz_nz;
            C_COND_PZT1T2_100: w_cond_ok = r_pz_nz & !r_t1_nz & !r_t2_nz;
            C_COND_PZT1T2_101: w_cond_ok = r_pz_nz & !r_t1_nz & r_t2_nz;
            default:           w_cond_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the last ROM address is terminal so pc never wraps
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_dec_code == C_OP_RDY) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_cond_ok) begin
                    w_state_nxt = w_pc_last ? S_IDLE : S_FETCH;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (op_rdy) begin
                    w_state_nxt = w_pc_last ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Start-edge detector; tracks ena every cycle so a held level never restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena_dly <= 1'b0;
        end else begin
            r_ena_dly <= ena;
        end
    end

    // Program counter: cleared on start, advanced after a skip or a completed op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_pc <= '0;
        end else if ((w_dec_skip || w_wait_done) && !w_pc_last) begin
            r_pc <= r_pc + C_PC_ONE;
        end
    end

    // Zero/non-zero flags, written by CMP completion according to src1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pz_nz <= 1'b0;
            r_t1_nz <= 1'b0;
            r_t2_nz <= 1'b0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_pz_nz <= 1'b0;
            r_t1_nz <= 1'b0;
            r_t2_nz <= 1'b0;
        end else if (w_wait_done && (r_op_code == C_OP_CMP)) begin
            if (r_op_src1 == C_SRC_PZ) begin
                r_pz_nz <= ~cmp_eq;
            end
            if (r_op_src1 == C_SRC_T1) begin
                r_t1_nz <= ~cmp_eq;
            end
            if (r_op_src1 == C_SRC_T2) begin
                r_t2_nz <= ~cmp_eq;
            end
        end
    end

    // Issued fields, held stable from ISSUE until the next issued micro-op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_code <= '0;
            r_op_src1 <= '0;
            r_op_src2 <= '0;
            r_op_dst  <= '0;
        end else if (w_dec_issue) begin
            r_op_code <= rom_data[19:16];
            r_op_src1 <= rom_data[15:11];
            r_op_src2 <= rom_data[10:6];
            r_op_dst  <= rom_data[5:2];
        end
    end

    assign rdy      = (r_state == S_IDLE);
    assign op_ena   = (r_state == S_ISSUE);
    assign rom_addr = r_pc;
    assign op_code  = r_op_code;
    assign op_src1  = r_op_src1;
    assign op_src2  = r_op_src2;
    assign op_dst   = r_op_dst;

    // The RDY decode is folded into the next-state logic; keep it observable
    logic w_unused;
    assign w_unused = w_dec_rdy;

endmodule
`default_nettype wire

// File: tb/tb_uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uop_sequencer
// Description : Scoreboard bench for uop_sequencer. A small point-addition
//               microprogram lives in a bench ROM; each scenario pushes the
//               hand-chosen list of addresses it expects to be issued, and a
//               monitor pops and compares on every op_ena pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uop_sequencer;

    localparam int ADDR_W = 6;

    localparam logic [3:0] OP_RDY = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [4:0] S_ZERO = 5'd0;
    localparam logic [4:0] S_ONE  = 5'd1;
    localparam logic [4:0] S_GX   = 5'd2;
    localparam logic [4:0] S_GY   = 5'd3;
    localparam logic [4:0] S_HX   = 5'd4;
    localparam logic [4:0] S_HY   = 5'd5;
    localparam logic [4:0] S_PZ   = 5'd8;
    localparam logic [4:0] S_T1   = 5'd11;
    localparam logic [4:0] S_T2   = 5'd12;
    localparam logic [3:0] D_RX   = 4'd0;
    localparam logic [3:0] D_RY   = 4'd1;
    localparam logic [3:0] D_RZ   = 4'd2;
    localparam logic [1:0] C_ALW  = 2'd0;
    localparam logic [1:0] C_0XX  = 2'd1;
    localparam logic [1:0] C_100  = 2'd2;
    localparam logic [1:0] C_101  = 2'd3;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              ena    = 1'b0;
    logic              op_rdy = 1'b0;
    logic              cmp_eq = 1'b0;
    logic [19:0]       rom_data = '0;
    logic              rdy;
    logic              op_ena;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        op_code;
    logic [4:0]        op_src1;
    logic [4:0]        op_src2;
    logic [3:0]        op_dst;

    logic [19:0] rom [0:63];
    int          dly [0:63];
    logic        cmp_at0, cmp_at8, cmp_at9;
    logic [23:0] exp_q [$];
    int          compared   = 0;
    int          mismatched = 0;
    int          pulses     = 0;
    int          cyc        = 0;

    uop_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rdy      (rdy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .op_ena   (op_ena),
        .op_code  (op_code),
        .op_src1  (op_src1),
        .op_src2  (op_src2),
        .op_dst   (op_dst),
        .op_rdy   (op_rdy),
        .cmp_eq   (cmp_eq)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [19:0] word(input logic [3:0] op, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [3:0] d,
                                         input logic [1:0] c);
        return {op, s1, s2, d, c};
    endfunction

    function automatic logic cmp_for(input logic [ADDR_W-1:0] a);
        if (a == 6'd0) return cmp_at0;
        if (a == 6'd8) return cmp_at8;
        if (a == 6'd9) return cmp_at9;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_q.push_back({6'(a), rom[a][19:2]});
    endtask

    // Monitor: every issue strobe must match the head of the expected queue
    initial begin : monitor
        logic        prev;
        logic [23:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (op_ena === 1'b1) begin
                pulses++;
                check("op_ena_back_to_back", {31'd0, prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_issue: op_ena at addr %0d, expected no issue", rom_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("issued_op", {8'd0, rom_addr, op_code, op_src1, op_src2, op_dst}, {8'd0, e});
                end
            end
            prev = op_ena;
        end
    end

    // Datapath model: completes each op after dly[addr] WAIT cycles
    initial begin : datapath
        logic [ADDR_W-1:0] a;
        logic [17:0]       cap;
        forever begin
            @(negedge clk);
            if (rst_n && op_ena === 1'b1) begin
                a   = rom_addr;
                cap = {op_code, op_src1, op_src2, op_dst};
                @(negedge clk);
                for (int k = 1; k < dly[a]; k++) begin
                    if (!rst_n) break;
                    check("op_stable_in_wait", {14'd0, op_code, op_src1, op_src2, op_dst}, {14'd0, cap});
                    @(negedge clk);
                end
                if (rst_n) begin
                    check("op_stable_in_wait", {14'd0, op_code, op_src1, op_src2, op_dst}, {14'd0, cap});
                    op_rdy = 1'b1;
                    cmp_eq = cmp_for(a);
                    @(negedge clk);
                    op_rdy = 1'b0;
                    cmp_eq = 1'b0;
                end
            end
        end
    end

    task automatic set_cmp(input logic c0, input logic c8, input logic c9);
        cmp_at0 = c0;
        cmp_at8 = c8;
        cmp_at9 = c9;
    endtask

    // Start on a fresh ena edge, wait for rdy and check latency / queue drain
    task automatic run_prog(input string name, input int exp_lat, input int exp_pulses,
                            input int toggle_at);
        int c0, n, p0;
        p0 = pulses;
        @(negedge clk); ena = 1'b0;
        @(negedge clk); ena = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        check({name, "_rdy_low_after_start"}, {31'd0, rdy}, 32'd0);
        n = 0;
        while (!rdy && n < 5000) begin
            if (toggle_at > 0 && n == toggle_at)     ena = 1'b0;
            if (toggle_at > 0 && n == toggle_at + 1) ena = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: rdy still 0 after %0d cycles, required 1", name, n);
        end else begin
            check({name, "_latency"}, cyc - c0, exp_lat);
        end
        check({name, "_pulses"}, pulses - p0, exp_pulses);
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : main
        int p0, n;
        for (int i = 0; i < 64; i++) begin
            rom[i] = word(OP_RDY, S_ZERO, S_ZERO, D_RX, C_ALW);
            dly[i] = 1;
        end
        for (int i = 1; i < 24; i++)
            rom[i] = word(OP_ADD + 4'(i % 3), 5'(i), 5'(31 - i), 4'(i % 16), C_ALW);
        rom[0]  = word(OP_CMP, S_PZ, S_ZERO, D_RX, C_ALW);
        rom[2]  = word(OP_MUL, S_GX, S_GY, 4'd5, C_ALW);
        rom[8]  = word(OP_CMP, S_T1, S_ZERO, D_RX, C_ALW);
        rom[9]  = word(OP_CMP, S_T2, S_ZERO, D_RX, C_ALW);
        rom[24] = word(OP_MOV, S_GX,  S_ZERO, D_RX, C_0XX);
        rom[25] = word(OP_MOV, S_GY,  S_ZERO, D_RY, C_0XX);
        rom[26] = word(OP_MOV, S_ONE, S_ZERO, D_RZ, C_0XX);
        rom[27] = word(OP_MOV, S_HX,  S_ZERO, D_RX, C_100);
        rom[28] = word(OP_MOV, S_HY,  S_ZERO, D_RY, C_100);
        rom[29] = word(OP_MOV, S_ONE, S_ZERO, D_RZ, C_100);
        rom[30] = word(OP_MOV, S_ONE, S_ZERO, D_RX, C_101);
        rom[31] = word(OP_MOV, S_ONE, S_ZERO, D_RY, C_101);
        rom[32] = word(OP_MOV, S_ZERO, S_ZERO, D_RZ, C_101);
        set_cmp(1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rdy",      {31'd0, rdy},    32'd1);
        check("reset_op_ena",   {31'd0, op_ena}, 32'd0);
        check("reset_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("reset_op_code",  {28'd0, op_code}, 32'd0);
        check("reset_op_src1",  {27'd0, op_src1}, 32'd0);
        check("reset_op_src2",  {27'd0, op_src2}, 32'd0);
        check("reset_op_dst",   {28'd0, op_dst},  32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Generic addition: 0..23 issued, 24..32 skipped, 24*4 + 9*2 + 2
        set_cmp(1'b0, 1'b0, 1'b0);
        push_range(0, 23);
        run_prog("generic", 116, 24, 0);

        // ena held high after completion must not restart
        p0 = pulses;
        repeat (20) @(negedge clk);
        check("held_ena_rdy", {31'd0, rdy}, 32'd1);
        check("held_ena_no_issue", pulses - p0, 0);

        // MUL at address 2 completes after 5 WAIT cycles: latency +4
        dly[2] = 5;
        push_range(0, 23);
        run_prog("mul_delay", 120, 24, 0);
        dly[2] = 1;

        // PZ == 0: MOV G_X, G_Y, ONE issued; ena pulsed mid-run is ignored
        set_cmp(1'b1, 1'b0, 1'b0);
        push_range(0, 26);
        run_prog("pz_zero", 122, 27, 15);

        // Doubling: H_X, H_Y, ONE
        set_cmp(1'b0, 1'b1, 1'b1);
        push_range(0, 23);
        push_range(27, 29);
        run_prog("doubling", 122, 27, 0);

        // Inverse: ONE, ONE, ZERO
        set_cmp(1'b0, 1'b1, 1'b0);
        push_range(0, 23);
        push_range(30, 32);
        run_prog("inverse", 122, 27, 0);

        // Async reset while waiting on address 10
        set_cmp(1'b0, 1'b0, 1'b0);
        dly[10] = 40;
        push_range(0, 10);
        p0 = pulses;
        @(negedge clk); ena = 1'b0;
        @(negedge clk); ena = 1'b1;
        n = 0;
        while (pulses < p0 + 11 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_addr10", pulses - p0, 11);
        repeat (2) @(negedge clk);
        check("rst_in_wait_addr", {26'd0, rom_addr}, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_rdy",    {31'd0, rdy},    32'd1);
        check("rst_async_op_ena", {31'd0, op_ena}, 32'd0);
        p0 = pulses;
        repeat (5) @(negedge clk);
        check("rst_no_issue",      pulses - p0, 0);
        check("rst_rom_addr",      {26'd0, rom_addr}, 32'd0);
        check("rst_op_code",       {28'd0, op_code}, 32'd0);
        check("rst_queue_drained", exp_q.size(), 0);
        ena = 1'b0;
        dly[10] = 1;
        @(negedge clk); rst_n = 1'b1;

        // Restart after reset runs the doubling program from address 0
        set_cmp(1'b0, 1'b1, 1'b1);
        push_range(0, 23);
        push_range(27, 29);
        run_prog("restart", 122, 27, 0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
